router_port: RTL and testbench
==============================

# router_port

One port of the NoC router: the router-side end of the byte-serial node link. The receive half accepts 4-byte packets from a node over the put/free/payload handshake, reassembles them into 32-bit packets and queues them toward the router crossbar. The transmit half takes one 32-bit packet at a time from the crossbar and serializes it to the node over the same handshake in the opposite direction. One instance sits between each node and the router switching logic.

## Interface
- DEPTH, 2, receive queue depth in packets (≥1)
- clock  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- rx_put  in  1  node is driving a packet byte this cycle
- rx_payload  in  8  byte from node
- rx_free  out  1  port can accept a new packet from node
- out_pkt  out  32  head-of-queue packet {src[31:28], dest[27:24], data[23:0]}
- out_valid  out  1  out_pkt valid (queue not empty)
- out_ready  in  1  crossbar consumes head packet
- in_pkt  in  32  packet from crossbar for this node
- in_valid  in  1  in_pkt valid
- in_ready  out  1  port accepts in_pkt this cycle
- tx_put  out  1  port is driving a packet byte this cycle
- tx_payload  out  8  byte to node
- tx_free  in  1  node can accept a new packet

## Operation
- Byte order on both links: byte0 = {src,dest} = pkt[31:24], byte1 = pkt[23:16], byte2 = pkt[15:8], byte3 = pkt[7:0]; bytes are on consecutive cycles with put=1.
- Receive FSM states: IDLE, B1, B2, B3 (bytes already held).
  - IDLE: rx_put && rx_free → capture byte0, go B1. rx_put while rx_free=0 is a protocol violation; the byte is ignored and the FSM stays IDLE.
  - B1/B2: rx_put → capture byte, advance. rx_put=0 → hold state and bytes.
  - B3: rx_put → write assembled packet into queue tail, go IDLE.
- rx_free = (state==IDLE) && (count < DEPTH); a pure function of flops.
- Queue: circular buffer, wrapping pointers, count 0..DEPTH. out_valid = count!=0; out_pkt = head entry (combinational read).
- Pop when out_valid && out_ready; out_ready with empty queue is ignored.
- Push and pop on the same edge: both pointers advance, count unchanged. Push when count==DEPTH cannot occur because rx_free gated entry.
- Transmit FSM states: IDLE, WAIT, SEND, DONE.
  - in_ready = (state==IDLE). IDLE: in_valid → latch in_pkt, go WAIT.
  - WAIT: tx_free sampled 1 → tx_put<=1, tx_payload<=byte0, go SEND with index 1.
  - SEND: drive bytes 1,2,3 on successive edges with tx_put=1; after byte3, go DONE.
  - DONE: tx_put<=0, go IDLE.
- tx_free is sampled only in WAIT; changes during SEND are ignored.
- tx_payload holds its last value while tx_put=0.

## Timing
- Reset: rx_free=0 while asserted (state IDLE, count 0 gives 1 after release), out_valid=0, out_pkt=0, in_ready=0 during reset and 1 after, tx_put=0, tx_payload=0. All FSMs go to IDLE, pointers and count are cleared, and queue contents are zeroed.
- Reset mid-packet on either side discards the partial packet. No bytes are emitted after reset.
- Receive latency: byte3 sampled at edge N → out_valid=1 and out_pkt valid after edge N.
- Transmit: accept at edge E → earliest byte0 after edge E+1 (when tx_free=1 at E+1). Bytes follow at E+2..E+4. tx_put falls after E+5. in_ready is high again after E+5.
- Minimum transmit period: 6 cycles per packet. Receive sustains back-to-back packets while the queue has space.

## Test plan
- Reset release, then node sends 0x12,0xAB,0xCD,0xEF → out_pkt=0x12ABCDEF, out_valid=1 one cycle after the last byte; rx_free stays 1 (DEPTH=2, count=1).
- Two packets arrive with out_ready=0 → count=2, rx_free=0. A third rx_put burst is ignored. Pop one → rx_free=1, and a new packet is received and ordered after the remaining one.
- Pop and push complete on the same edge with count=1 → count stays 1, and the head becomes the newly received packet; covers pointer wrap.
- in_pkt=0x34112233 with tx_free=0 for 3 cycles, then 1 → tx_put high for exactly 4 cycles carrying 0x34,0x11,0x22,0x33; in_ready stays low until after DONE.
- Loopback: tx output drives a Node model and the Node model drives rx. Ten random packets → each is received intact and in order.
- reset_n asserted after byte1 on rx and after byte2 on tx → all outputs return to reset values immediately. No out_valid appears and no tx_put is driven afterward.

Source files
------------

// File: rtl/router_port_if.sv
// Router-port link bundle: byte-serial node link on both directions plus the
// crossbar-side packet handshakes. The slave view belongs to router_port.
interface router_port_if;
    logic        rx_put;
    logic [7:0]  rx_payload;
    logic        rx_free;
    logic [31:0] out_pkt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] in_pkt;
    logic        in_valid;
    logic        in_ready;
    logic        tx_put;
    logic [7:0]  tx_payload;
    logic        tx_free;

    modport master (
        output rx_put, rx_payload, out_ready, in_pkt, in_valid, tx_free,
        input  rx_free, out_pkt, out_valid, in_ready, tx_put, tx_payload
    );

    modport slave (
        input  rx_put, rx_payload, out_ready, in_pkt, in_valid, tx_free,
        output rx_free, out_pkt, out_valid, in_ready, tx_put, tx_payload
    );
endinterface

// File: rtl/router_port.sv
// Router-side end of a byte-serial node link: rx reassembles 4-byte packets into a queue,
// tx serializes one crossbar packet. rx: IDLE|B1|B2|B3 = bytes held; tx: IDLE|WAIT|SEND|DONE.
module router_port #(
    parameter int DEPTH = 2
) (
    input logic        clock,
    input logic        reset_n,
    router_port_if.slave bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {RX_IDLE, RX_B1, RX_B2, RX_B3} rx_state_e;
    typedef enum logic [1:0] {TX_IDLE, TX_WAIT, TX_SEND, TX_DONE} tx_state_e;

    rx_state_e   rx_state_q;
    tx_state_e   tx_state_q;
    logic        rdy_q;
    logic [7:0]  rx_b0_q, rx_b1_q, rx_b2_q;
    logic [31:0] mem_q [DEPTH];
    logic [PW-1:0] head_q, tail_q, head_d, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0] tx_sh_q;
    logic [1:0]  tx_idx_q;
    logic        tx_put_q;
    logic [7:0]  tx_payload_q;
    logic        rx_free, in_ready, push, pop;

    function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // rdy_q keeps both handshakes low while reset is asserted
    assign rx_free = rdy_q && (rx_state_q == RX_IDLE) && (count_q < CW'(DEPTH));
    assign in_ready = rdy_q && (tx_state_q == TX_IDLE);
    assign push = bus.rx_put && (rx_state_q == RX_B3);
    assign pop = bus.out_ready && (count_q != '0);

    always_comb begin
        head_d = pop ? inc_ptr(head_q) : head_q;
        tail_d = push ? inc_ptr(tail_q) : tail_q;
        count_d = count_q;
        if (push && !pop) count_d = count_q + 1'b1;
        else if (!push && pop) count_d = count_q - 1'b1;
    end

    assign bus.rx_free = rx_free;
    assign bus.in_ready = in_ready;
    assign bus.out_valid = (count_q != '0);
    assign bus.out_pkt = mem_q[head_q];
    assign bus.tx_put = tx_put_q;
    assign bus.tx_payload = tx_payload_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rdy_q <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_state_q <= RX_IDLE;
            rx_b0_q <= '0;
            rx_b1_q <= '0;
            rx_b2_q <= '0;
        end else begin
            case (rx_state_q)
                RX_IDLE: if (bus.rx_put && rx_free) begin
                    rx_b0_q <= bus.rx_payload;
                    rx_state_q <= RX_B1;
                end
                RX_B1: if (bus.rx_put) begin
                    rx_b1_q <= bus.rx_payload;
                    rx_state_q <= RX_B2;
                end
                RX_B2: if (bus.rx_put) begin
                    rx_b2_q <= bus.rx_payload;
                    rx_state_q <= RX_B3;
                end
                RX_B3: if (bus.rx_put) rx_state_q <= RX_IDLE;
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            head_q <= '0;
            tail_q <= '0;
            count_q <= '0;
        end else begin
            if (push) mem_q[tail_q] <= {rx_b0_q, rx_b1_q, rx_b2_q, bus.rx_payload};
            head_q <= head_d;
            tail_q <= tail_d;
            count_q <= count_d;
        end
    end

    // tx_sh_q shifts left so the next byte to send is always in the top lane
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tx_state_q <= TX_IDLE;
            tx_sh_q <= '0;
            tx_idx_q <= '0;
            tx_put_q <= 1'b0;
            tx_payload_q <= '0;
        end else begin
            case (tx_state_q)
                TX_IDLE: if (bus.in_valid && in_ready) begin
                    tx_sh_q <= bus.in_pkt;
                    tx_state_q <= TX_WAIT;
                end
                TX_WAIT: if (bus.tx_free) begin
                    tx_put_q <= 1'b1;
                    tx_payload_q <= tx_sh_q[31:24];
                    tx_sh_q <= {tx_sh_q[23:0], 8'h00};
                    tx_idx_q <= 2'd1;
                    tx_state_q <= TX_SEND;
                end
                TX_SEND: begin
                    tx_payload_q <= tx_sh_q[31:24];
                    tx_sh_q <= {tx_sh_q[23:0], 8'h00};
                    tx_idx_q <= tx_idx_q + 2'd1;
                    if (tx_idx_q == 2'd3) tx_state_q <= TX_DONE;
                end
                TX_DONE: begin
                    tx_put_q <= 1'b0;
                    tx_state_q <= TX_IDLE;
                end
                default: tx_state_q <= TX_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_router_port.sv
// Directed and randomized checks of router_port against a packet-level queue model.
module tb_router_port;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int tests = 0;
    int fails = 0;
    logic [31:0] exp_q[$];

    router_port_if bus();

    router_port #(.DEPTH(2)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus.slave)
    );

    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rx_send(input logic [31:0] pkt, input bit pop_last);
        for (int i = 0; i < 4; i++) begin
            bus.rx_put = 1'b1;
            bus.rx_payload = pkt[(31 - 8 * i) -: 8];
            if (i == 3 && pop_last) bus.out_ready = 1'b1;
            tick();
        end
        bus.rx_put = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    task automatic wait_rx_free(input string tag);
        int n = 0;
        while (!bus.rx_free && n < 20) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, bus.rx_free}, 32'd1);
    endtask

    task automatic pop_check(input string tag);
        chk({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
        if (exp_q.size() > 0) begin
            chk({tag, "_pkt"}, bus.out_pkt, exp_q[0]);
            void'(exp_q.pop_front());
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    // Node model: accept one packet from the crossbar side and capture the link bytes.
    task automatic tx_send(input logic [31:0] pkt, output logic [31:0] word);
        int n = 0;
        int got = 0;
        word = '0;
        bus.in_pkt = pkt;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 20) begin
            tick();
            n++;
        end
        chk("tx_in_ready_wait", {31'd0, bus.in_ready}, 32'd1);
        tick();
        bus.in_valid = 1'b0;
        bus.tx_free = 1'b1;
        n = 0;
        while (got < 4 && n < 30) begin
            tick();
            n++;
            if (bus.tx_put) begin
                word = {word[23:0], bus.tx_payload};
                got++;
            end
        end
        chk("tx_bytes_seen", got, 4);
        n = 0;
        while (bus.tx_put && n < 10) begin
            tick();
            n++;
        end
        chk("tx_put_fall", {31'd0, bus.tx_put}, 32'd0);
    endtask

    initial begin
        logic [31:0] p2, p4, p5, p6, pkt, word;
        logic [7:0] tb_bytes[4];
        int nb, put_cycles, got;

        bus.rx_put = 0; bus.rx_payload = 0; bus.out_ready = 0;
        bus.in_pkt = 0; bus.in_valid = 0; bus.tx_free = 0;

        tick(); tick();
        chk("rst_rx_free", {31'd0, bus.rx_free}, 32'd0);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_out_pkt", bus.out_pkt, 32'd0);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("rst_tx_put", {31'd0, bus.tx_put}, 32'd0);
        chk("rst_tx_payload", {24'd0, bus.tx_payload}, 32'd0);
        reset_n = 1'b1;
        tick(); tick();
        chk("rel_rx_free", {31'd0, bus.rx_free}, 32'd1);
        chk("rel_in_ready", {31'd0, bus.in_ready}, 32'd1);

        // First packet: visible right after the edge that samples byte3
        for (int i = 0; i < 3; i++) begin
            bus.rx_put = 1'b1;
            bus.rx_payload = 32'h12ABCDEF >> (24 - 8 * i);
            tick();
        end
        chk("rx1_not_yet", {31'd0, bus.out_valid}, 32'd0);
        bus.rx_payload = 8'hEF;
        tick();
        bus.rx_put = 1'b0;
        exp_q.push_back(32'h12ABCDEF);
        chk("rx1_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("rx1_pkt", bus.out_pkt, 32'h12ABCDEF);
        chk("rx1_free", {31'd0, bus.rx_free}, 32'd1);

        // Fill to DEPTH, then an ignored burst
        p2 = $urandom;
        rx_send(p2, 1'b0);
        exp_q.push_back(p2);
        chk("full_rx_free", {31'd0, bus.rx_free}, 32'd0);
        rx_send($urandom, 1'b0);
        chk("ign_rx_free", {31'd0, bus.rx_free}, 32'd0);
        chk("ign_head", bus.out_pkt, 32'h12ABCDEF);
        pop_check("pop1");
        chk("after_pop_free", {31'd0, bus.rx_free}, 32'd1);
        p4 = $urandom;
        wait_rx_free("p4_free");
        rx_send(p4, 1'b0);
        exp_q.push_back(p4);
        pop_check("pop2");
        pop_check("pop4");
        chk("drained", {31'd0, bus.out_valid}, 32'd0);

        // Simultaneous push and pop with one entry held
        p5 = $urandom;
        p6 = $urandom;
        rx_send(p5, 1'b0);
        exp_q.push_back(p5);
        rx_send(p6, 1'b1);
        void'(exp_q.pop_front());
        exp_q.push_back(p6);
        chk("pp_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("pp_head", bus.out_pkt, p6);
        chk("pp_free", {31'd0, bus.rx_free}, 32'd1);
        pop_check("pp_pop");
        chk("pp_empty", {31'd0, bus.out_valid}, 32'd0);

        // Transmit with tx_free held low for three WAIT cycles
        bus.in_pkt = 32'h34112233;
        bus.in_valid = 1'b1;
        bus.tx_free = 1'b0;
        chk("tx_ready_idle", {31'd0, bus.in_ready}, 32'd1);
        tick();
        bus.in_valid = 1'b0;
        chk("tx_busy", {31'd0, bus.in_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("tx_wait_no_put", {31'd0, bus.tx_put}, 32'd0);
        end
        bus.tx_free = 1'b1;
        nb = 0;
        put_cycles = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (bus.tx_put) begin
                put_cycles++;
                if (nb < 4) tb_bytes[nb] = bus.tx_payload;
                nb++;
                bus.tx_free = 1'b0;
                chk("tx_ready_low", {31'd0, bus.in_ready}, 32'd0);
            end else if (nb > 0) begin
                break;
            end
        end
        chk("tx_put_cycles", put_cycles, 4);
        if (nb >= 4) begin
            chk("tx_b0", {24'd0, tb_bytes[0]}, 32'h34);
            chk("tx_b1", {24'd0, tb_bytes[1]}, 32'h11);
            chk("tx_b2", {24'd0, tb_bytes[2]}, 32'h22);
            chk("tx_b3", {24'd0, tb_bytes[3]}, 32'h33);
        end
        chk("tx_ready_again", {31'd0, bus.in_ready}, 32'd1);
        chk("tx_payload_hold", {24'd0, bus.tx_payload}, 32'h33);

        // Loopback of ten random packets through the node model
        for (int k = 0; k < 10; k++) begin
            pkt = $urandom;
            tx_send(pkt, word);
            chk("lb_tx_word", word, pkt);
            if (exp_q.size() == 2) pop_check("lb_pop_full");
            wait_rx_free("lb_free");
            rx_send(word, 1'b0);
            exp_q.push_back(pkt);
            if ($urandom_range(0, 1) == 1) pop_check("lb_pop");
        end
        while (exp_q.size() > 0) pop_check("lb_drain");
        chk("lb_empty", {31'd0, bus.out_valid}, 32'd0);

        // Reset in the middle of an rx packet
        bus.tx_free = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.rx_put = 1'b1;
            bus.rx_payload = $urandom;
            tick();
        end
        bus.rx_put = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("rxrst_free", {31'd0, bus.rx_free}, 32'd0);
        chk("rxrst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rxrst_pkt", bus.out_pkt, 32'd0);
        chk("rxrst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("rxrst_no_valid", {31'd0, bus.out_valid}, 32'd0);
        end

        // Reset in the middle of a tx packet, after byte2 is on the link
        bus.in_pkt = $urandom;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.tx_free = 1'b1;
        got = 0;
        for (int c = 0; c < 20 && got < 3; c++) begin
            tick();
            if (bus.tx_put) got++;
        end
        chk("txrst_bytes", got, 3);
        reset_n = 1'b0;
        #1;
        chk("txrst_put", {31'd0, bus.tx_put}, 32'd0);
        chk("txrst_payload", {24'd0, bus.tx_payload}, 32'd0);
        chk("txrst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("txrst_no_put", {31'd0, bus.tx_put}, 32'd0);
            chk("txrst_no_valid", {31'd0, bus.out_valid}, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
